// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter and its companion receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: wraps every CLKS_PER_BIT clocks, held at zero while cleared.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_tick,
    output logic o_pre_tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE  = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (i_clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_bit_tick = (cnt_q == LAST);
    // One clock early, so registered outputs can line up with the last clock of a bit.
    assign o_pre_tick = (cnt_q == PRE);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, D_BITS data LSB first, optional parity, STOP_BITS stop bits.
// Parity stage is built only when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int D_BITS     = 8,
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115_200,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [D_BITS-1:0] i_data,
    input  logic              i_tx_enable,
    output logic              o_tx,
    output logic              o_tx_done,
    output logic              o_busy
);

    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int BCW = (D_BITS > 2) ? $clog2(D_BITS) : 1;
    localparam logic [BCW-1:0] DATA_LAST = BCW'(D_BITS - 1);
    localparam logic [BCW-1:0] STOP_LAST = BCW'(STOP_BITS - 1);

    if (CPB < 2 || (STOP_BITS != 1 && STOP_BITS != 2) || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx: unsupported parameter combination");
    end

    tx_state_t         state_q, state_d;
    logic [D_BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              bit_tick, pre_tick;
`ifdef UART_TX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT(CPB)
    ) u_baud (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (state_q == IDLE),
        .o_bit_tick (bit_tick),
        .o_pre_tick (pre_tick)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        done_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_tx_enable) begin
                    state_d   = START;
                    shreg_d   = i_data;
                    bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                    parity_d  = (^i_data) ^ (PARITY_ODD != 0);
`endif
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        shreg_d   = shreg_q >> 1;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_tick) begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                end
            end
`endif
            STOP: begin
                done_d = pre_tick && (bit_cnt_q == STOP_LAST);
                if (bit_tick) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so o_tx is a plain register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign o_tx      = tx_q;
    assign o_tx_done = done_q;
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx at 10 clocks per bit; the line is decoded by a monitor.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
    localparam int EXP_DONES = 5;
`else
    localparam int P = 0;
    localparam int EXP_DONES = 4;
`endif
    localparam int CPB = 10;
    localparam int FB  = 10 + P;
    localparam int NB  = FB * CPB;

    typedef struct {
        logic [7:0] data;
        logic       par;
        int         start_cyc;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp_v;
    } req_t;

    logic       clk, rst, en;
    logic [7:0] data;
    logic       tx, done, busy;

    exp_t exp_q[$];
    req_t chk_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_total = 0;

    uart_tx #(
        .D_BITS(8), .CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1), .PARITY_ODD(0)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_data(data), .i_tx_enable(en),
        .o_tx(tx), .o_tx_done(done), .o_busy(busy)
    );

`ifdef UART_TX_PARITY_EN
    logic       en_o;
    logic [7:0] data_o;
    logic       tx_o, done_o, busy_o;

    uart_tx #(
        .D_BITS(8), .CLK_FREQ(1_000_000), .BAUD(100_000), .STOP_BITS(1), .PARITY_ODD(1)
    ) dut_odd (
        .i_clk(clk), .i_rst(rst), .i_data(data_o), .i_tx_enable(en_o),
        .o_tx(tx_o), .o_tx_done(done_o), .o_busy(busy_o)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_check(input string n, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    task automatic req(input string n, input int a, input int e);
        req_t r;
        r.name  = n;
        r.act   = a;
        r.exp_v = e;
        chk_q.push_back(r);
    endtask

    // Monitor: drains stimulus-side checks and decodes every frame on the line.
    bit             mon_active = 0;
    bit             post_done  = 0;
    int             mon_cyc    = 0;
    logic [FB-1:0]  line_bits;
    exp_t           cur;

    always @(negedge clk) begin
        while (chk_q.size() > 0) begin
            req_t r;
            r = chk_q.pop_front();
            do_check(r.name, r.act, r.exp_v);
        end
        if (rst) begin
            mon_active = 0;
            post_done  = 0;
        end else begin
            if (post_done) begin
                post_done = 0;
                do_check("busy_after_done", int'(busy), 0);
            end
            if (!mon_active && tx == 1'b0) begin
                mon_active = 1;
                mon_cyc    = 0;
                line_bits  = '1;
                if (exp_q.size() == 0) begin
                    do_check("unexpected_frame", 1, 0);
                end else begin
                    do_check("start_latency", cyc, exp_q[0].start_cyc);
                end
                do_check("busy_at_start", int'(busy), 1);
            end
            if (done) done_total++;
            if (mon_active) begin
                if (mon_cyc % CPB == CPB / 2) line_bits[mon_cyc / CPB] = tx;
                if (mon_cyc == NB - 1) begin
                    do_check("done_at_frame_end", int'(done), 1);
                    do_check("busy_at_done", int'(busy), 1);
                    do_check("start_bit", int'(line_bits[0]), 0);
                    do_check("stop_bit", int'(line_bits[FB-1]), 1);
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        do_check("data_bits", int'(line_bits[8:1]), int'(cur.data));
`ifdef UART_TX_PARITY_EN
                        do_check("parity_bit", int'(line_bits[9]), int'(cur.par));
`endif
                        $display("frame data=%02h par=%0b start_cyc=%0d line=%b",
                                 cur.data, cur.par, cur.start_cyc, line_bits);
                    end
                    mon_active = 0;
                    post_done  = 1;
                end else if (done) begin
                    do_check("early_done", mon_cyc, NB - 1);
                end
                mon_cyc++;
            end else if (done) begin
                do_check("stray_done", 1, 0);
            end
        end
    end

    // Caller is positioned at a negedge; returns 1ns after the accepting edge.
    task automatic send_now(input logic [7:0] d, input logic par);
        exp_t e;
        data = d;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
        data = ~d;
        e.data      = d;
        e.par       = par;
        e.start_cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string n);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        if (!seen) req({n, "_timeout"}, 0, 1);
    endtask

    initial begin
        int s;
        rst  = 1'b1;
        en   = 1'b0;
        data = 8'h00;
`ifdef UART_TX_PARITY_EN
        en_o   = 1'b0;
        data_o = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1;
        req("reset_tx", int'(tx), 1);
        req("reset_busy", int'(busy), 0);
        req("reset_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;

        // Idle line after reset
        repeat (200) @(negedge clk);
        req("idle_tx", int'(tx), 1);
        req("idle_busy", int'(busy), 0);

        // 0x55 frame
        @(negedge clk);
        send_now(8'h55, 1'b0);
        wait_done("t2");

        // 0x55 with an ignored 0xFF mid-frame, then 0xFF on the done cycle, then 0xA3 back to back
        @(negedge clk);
        send_now(8'h55, 1'b0);
        repeat (40) @(negedge clk);
        data = 8'hFF;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
        data = 8'h00;
        wait_done("t3");
        data = 8'hFF;
        en   = 1'b1;
        @(negedge clk);
        send_now(8'hA3, 1'b0);
        wait_done("t4");

        // 0xF0 aborted by reset during data bit 3 (bit value 0)
        @(negedge clk);
        send_now(8'hF0, 1'b0);
        repeat (45) @(negedge clk);
        req("bit3_low_before_reset", int'(tx), 0);
        #1;
        rst = 1'b1;
        exp_q.delete();
        #1;
        req("async_reset_tx", int'(tx), 1);
        req("async_reset_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        send_now(8'h0F, 1'b0);
        wait_done("t5");

`ifdef UART_TX_PARITY_EN
        // 0x07: even parity 1 on the main instance, odd parity 0 on the second
        @(negedge clk);
        send_now(8'h07, 1'b1);
        s = cyc - 1;
        wait_done("t6");
        req("parity_frame_len", cyc - s, 110);

        @(negedge clk);
        data_o = 8'h07;
        en_o   = 1'b1;
        @(posedge clk);
        #1;
        en_o   = 1'b0;
        s      = cyc;
        repeat (96) @(negedge clk);
        req("odd_parity_bit", int'(tx_o), 0);
        begin
            bit seen;
            seen = 0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (done_o) begin
                    seen = 1;
                    break;
                end
            end
            req("odd_done_seen", int'(seen), 1);
            req("odd_frame_len", cyc - s + 1, 110);
        end
`endif

        repeat (5) @(negedge clk);
        req("done_count", done_total, EXP_DONES);
        req("scoreboard_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
